// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage status inputs and stall/bubble strobes between datapath and pipe_ctrl
interface pipe_ctrl_if;
    logic [3:0] d_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] e_icode;
    logic [3:0] e_dstM;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic [2:0] m_stat;
    logic [2:0] w_stat;
    logic       w_valid;
    logic       mem_busy;
    logic       f_stall;
    logic       d_stall;
    logic       w_stall;
    logic       d_bubble;
    logic       e_bubble;
    logic       m_bubble;
    logic       set_cc;

    modport master (
        output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_icode,
               m_stat, w_stat, w_valid, mem_busy,
        input  f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc
    );

    modport slave (
        input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_icode,
               m_stat, w_stat, w_valid, mem_busy,
        output f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86 pipeline hazard control, RUN/HALTED status FSM and saturating perf counters
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       pif,
    output logic             halted,
    output logic [2:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cpu_stat_q, cpu_stat_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic load_use, ret_pend, mispred, exc, w_bad, run;
    logic f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != {CNT_W{1'b1}}) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

    always_comb begin
        run      = (state_q == S_RUN);
        load_use = (pif.e_icode == I_MRMOVL || pif.e_icode == I_POPL) &&
                   pif.e_dstM != R_NONE &&
                   (pif.e_dstM == pif.d_srcA || pif.e_dstM == pif.d_srcB);
        ret_pend = (pif.d_icode == I_RET) || (pif.e_icode == I_RET) || (pif.m_icode == I_RET);
        mispred  = (pif.e_icode == I_JXX) && !pif.e_cnd;
        w_bad    = (pif.w_stat != STAT_AOK);
        exc      = (pif.m_stat != STAT_AOK) || w_bad;
    end

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        if (rst) begin
            f_stall = 1'b0;
        end else if (!run) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            w_stall = 1'b1;
        end else if (pif.mem_busy) begin
            // freeze everything; the M bubble stops the stalled access from repeating
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            w_stall  = 1'b1;
            m_bubble = 1'b1;
        end else begin
            if (load_use) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end
            if (mispred) begin
                d_bubble = 1'b1;
                e_bubble = 1'b1;
            end
            // a mispredict redirects fetch, so the ret hold is dropped
            if (ret_pend && !load_use && !mispred) begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
            end
            if (exc)   m_bubble = 1'b1;
            if (w_bad) w_stall  = 1'b1;
            if (d_stall) d_bubble = 1'b0;
        end
    end

    assign pif.f_stall  = f_stall;
    assign pif.d_stall  = d_stall;
    assign pif.w_stall  = w_stall;
    assign pif.d_bubble = d_bubble;
    assign pif.e_bubble = e_bubble;
    assign pif.m_bubble = m_bubble;
    assign pif.set_cc   = !rst && run && (pif.e_icode == I_OPL) && !exc;

    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        if (run && w_bad && !pif.mem_busy) begin
            state_d    = S_HALTED;
            cpu_stat_d = pif.w_stat;
        end
        cycle_d  = sat_inc(cycle_q, run);
        retire_d = sat_inc(retire_q, run && pif.w_valid && !w_bad && !pif.mem_busy);
        stall_d  = sat_inc(stall_q, run && (f_stall || d_bubble || e_bubble));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            cpu_stat_q <= STAT_AOK;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            stall_q    <= stall_d;
        end
    end

    assign halted     = (state_q == S_HALTED);
    assign cpu_stat   = cpu_stat_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed-vector self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        halted, halted_s;
    logic [2:0]  cpu_stat, cpu_stat_s;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt;
    logic [3:0]  cycle_s, retire_s, stall_s;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cyc = 0;
    int exp_ret = 0;
    int exp_stl = 0;

    pipe_ctrl_if pif ();
    pipe_ctrl_if sif ();

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pif(pif), .halted(halted), .cpu_stat(cpu_stat),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .pif(sif), .halted(halted_s), .cpu_stat(cpu_stat_s),
        .cycle_cnt(cycle_s), .retire_cnt(retire_s), .stall_cnt(stall_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {pif.f_stall, pif.d_stall, pif.w_stall, pif.d_bubble, pif.e_bubble, pif.m_bubble};
    endfunction

    task automatic idle();
        pif.d_icode = 4'h1; pif.d_srcA = 4'hF; pif.d_srcB = 4'hF;
        pif.e_icode = 4'h1; pif.e_dstM = 4'hF; pif.e_cnd = 1'b1;
        pif.m_icode = 4'h1; pif.m_stat = 3'd1; pif.w_stat = 3'd1;
        pif.w_valid = 1'b0; pif.mem_busy = 1'b0;
    endtask

    task automatic load_use_pat();
        pif.e_icode = 4'h5; pif.e_dstM = 4'h3; pif.d_srcA = 4'h3;
    endtask

    task automatic tick(input int c, input int r, input int s);
        @(posedge clk);
        #1;
        exp_cyc += c; exp_ret += r; exp_stl += s;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_cyc"}, cycle_cnt, exp_cyc);
        check({tag, "_ret"}, retire_cnt, exp_ret);
        check({tag, "_stl"}, stall_cnt, exp_stl);
    endtask

    initial begin
        sif.d_icode = 4'h1; sif.d_srcA = 4'hF; sif.d_srcB = 4'hF;
        sif.e_icode = 4'h1; sif.e_dstM = 4'hF; sif.e_cnd = 1'b1;
        sif.m_icode = 4'h1; sif.m_stat = 3'd1; sif.w_stat = 3'd1;
        sif.w_valid = 1'b0; sif.mem_busy = 1'b0;

        // reset with hazards present: controls must stay low
        rst = 1'b1;
        idle();
        load_use_pat();
        pif.mem_busy = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("rst_ctl", ctl(), 6'b000000);
        check("rst_halted", halted, 1'b0);
        check("rst_stat", cpu_stat, 3'd1);
        check_cnts("rst");

        rst = 1'b0;
        idle();
        pif.e_icode = 4'h6;
        #1;
        check("idle_ctl", ctl(), 6'b000000);
        check("idle_setcc", pif.set_cc, 1'b1);
        tick(1, 0, 0);

        idle();
        load_use_pat();
        #1;
        check("lu_ctl", ctl(), 6'b110010);
        tick(1, 0, 1);
        check("lu_stl", stall_cnt, 32'd1);

        // RET walks D, E, M: three cycles of f_stall + d_bubble
        idle(); pif.d_icode = 4'h9; #1;
        check("ret_d", ctl(), 6'b100100);
        tick(1, 0, 1);
        idle(); pif.e_icode = 4'h9; #1;
        check("ret_e", ctl(), 6'b100100);
        tick(1, 0, 1);
        idle(); pif.m_icode = 4'h9; #1;
        check("ret_m", ctl(), 6'b100100);
        tick(1, 0, 1);
        idle(); #1;
        check("ret_done", ctl(), 6'b000000);

        idle(); pif.e_icode = 4'h7; pif.e_cnd = 1'b0; pif.d_icode = 4'h9; #1;
        check("mis_ret", ctl(), 6'b000110);
        tick(1, 0, 1);
        idle(); pif.e_icode = 4'h7; pif.e_cnd = 1'b1; #1;
        check("jmp_taken", ctl(), 6'b000000);

        idle(); pif.w_valid = 1'b1; #1;
        tick(1, 1, 0);
        check_cnts("retire");

        idle(); load_use_pat(); pif.w_valid = 1'b1; pif.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("busy%0d", i), ctl(), 6'b111001);
            tick(1, 0, 1);
        end
        check_cnts("busy");

        idle(); pif.e_icode = 4'h6; pif.m_stat = 3'd2; #1;
        check("hlt_m_ctl", ctl(), 6'b000001);
        check("hlt_m_setcc", pif.set_cc, 1'b0);
        tick(1, 0, 0);
        idle(); pif.w_stat = 3'd2; pif.w_valid = 1'b1; #1;
        check("hlt_w_ctl", ctl(), 6'b001001);
        check("hlt_w_halted", halted, 1'b0);
        tick(1, 0, 0);
        idle(); load_use_pat(); pif.w_valid = 1'b1; #1;
        check("halted", halted, 1'b1);
        check("halt_stat", cpu_stat, 3'd2);
        check("halt_ctl", ctl(), 6'b111000);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_cnts("frozen");
        check("halt_hold", halted, 1'b1);

        rst = 1'b1;
        tick(0, 0, 0);
        exp_cyc = 0; exp_ret = 0; exp_stl = 0;
        check("rst2_stat", cpu_stat, 3'd1);
        check("rst2_halted", halted, 1'b0);
        check_cnts("rst2");
        check("rst2_small", cycle_s, 4'd0);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 14; i++) tick(1, 0, 0);
        check("sat_pre", cycle_s, 4'd14);
        for (int i = 0; i < 6; i++) tick(1, 0, 0);
        check("sat_hold", cycle_s, 4'd15);
        check("sat_wide", cycle_cnt, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
